// File: rtl/phase1_arbiter.sv
// Round-robin scheduler feeding one shared phase1 (sigmoid) unit; holds the teta register.
// Latency 2 cycles grant-to-response; rsp_ready low stalls S2, then S1, then grants.
`timescale 1ns/1ps
module phase1_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*64-1:0] x_in,
  output logic [NREQ-1:0]   gnt,
  input  logic              teta_wr,
  input  logic [63:0]       teta_in,
  output logic              teta_ack,
  output logic [63:0]       ph_x,
  output logic [63:0]       ph_teta,
  input  logic [7:0]        ph_h,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_h,
  output logic              busy
);

  logic            r_s1_valid;
  logic [IDW-1:0]  r_s1_id;
  logic [63:0]     r_ph_x;
  logic [63:0]     r_teta;
  logic [IDW-1:0]  r_ptr;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [7:0]      r_rsp_h;

  logic            w_s2_free;
  logic            w_s1_adv;
  logic            w_s1_free;
  logic            w_grant;
  logic            w_pick_vld;
  logic [IDW-1:0]  w_pick_idx;
  logic [IDW:0]    w_cand;
  logic [63:0]     w_x [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_xslice
    assign w_x[g] = x_in[64*g +: 64];
  end

  assign w_s2_free = !r_rsp_valid || rsp_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_s1_free = !r_s1_valid || w_s1_adv;

  // Search starts just after the last winner and wraps, so every requester gets a turn.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_cand >= (IDW+1)'(NREQ)) begin
        w_cand = w_cand - (IDW+1)'(NREQ);
      end
      if (!w_pick_vld && req[w_cand[IDW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand[IDW-1:0];
      end
    end
  end

  // teta only changes with S1 empty and blocks grants, so no sample sees a mixed teta.
  assign teta_ack = !rst && teta_wr && !r_s1_valid;
  assign w_grant  = !rst && !teta_wr && w_s1_free && w_pick_vld;
  assign gnt      = w_grant ? (NREQ'(1) << w_pick_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_ph_x      <= '0;
      r_teta      <= '0;
      r_ptr       <= IDW'(NREQ-1);
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_h     <= '0;
    end else begin
      if (teta_ack) begin
        r_teta <= teta_in;
      end
      if (w_grant) begin
        r_s1_valid <= 1'b1;
        r_s1_id    <= w_pick_idx;
        r_ph_x     <= w_x[w_pick_idx];
        r_ptr      <= w_pick_idx;
      end else if (w_s1_free) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s1_adv) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_s1_id;
        r_rsp_h     <= ph_h;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign ph_x      = r_ph_x;
  assign ph_teta   = r_teta;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_h     = r_rsp_h;
  assign busy      = r_s1_valid || r_rsp_valid;

endmodule

// File: tb/tb_phase1_arbiter.sv
// Directed bench for phase1_arbiter with a behavioural phase1 stand-in and a response scoreboard.
`timescale 1ns/1ps
module tb_phase1_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [255:0]  x_in;
  logic [3:0]    gnt;
  logic          teta_wr;
  logic [63:0]   teta_in;
  logic          teta_ack;
  logic [63:0]   ph_x;
  logic [63:0]   ph_teta;
  logic [7:0]    ph_h;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [7:0]    rsp_h;
  logic          busy;

  typedef struct {
    logic [1:0] id;
    logic [7:0] h;
  } exp_t;

  exp_t        q[$];
  logic [63:0] m_teta = '0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          n_gnt;
  logic [7:0]  held_h;
  logic [3:0]  e_gnt;

  always #5 clk = ~clk;

  // Stand-in for phase1: saturated byte-wise dot product.
  function automatic logic [7:0] model_h(input logic [63:0] x, input logic [63:0] t);
    logic [18:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + 19'(x[8*i +: 8]) * 19'(t[8*i +: 8]);
    end
    return (s > 19'd255) ? 8'hFF : s[7:0];
  endfunction

  assign ph_h = model_h(ph_x, ph_teta);

  phase1_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .gnt(gnt),
    .teta_wr(teta_wr), .teta_in(teta_in), .teta_ack(teta_ack),
    .ph_x(ph_x), .ph_teta(ph_teta), .ph_h(ph_h),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_h(rsp_h), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on each grant, pop on each accepted response.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_teta = '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rsp_without_grant", 64'(q.size() != 0), 64'd1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_rsp_id", 64'(rsp_id), 64'(e.id));
          chk("sb_rsp_h", 64'(rsp_h), 64'(e.h));
        end
      end
      if (gnt != 4'b0) begin
        exp_t e;
        chk("gnt_onehot", 64'($onehot(gnt)), 64'd1);
        chk("gnt_without_req", 64'(gnt & ~req), 64'd0);
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) begin
            e.id = 2'(i);
            e.h  = model_h(x_in[64*i +: 64], m_teta);
          end
        end
        q.push_back(e);
      end
      if (teta_ack) m_teta = teta_in;
    end
  end

  initial begin
    rst = 1'b1; req = '0; teta_wr = 1'b0; teta_in = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) x_in[64*i +: 64] = {8{8'(i + 2)}};
    tick(); tick();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_h", 64'(rsp_h), 64'd0);
    chk("rst_ph_x", ph_x, 64'd0);
    chk("rst_ph_teta", ph_teta, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // teta load, then a single sample from requester 0
    tick(); teta_wr = 1'b1; teta_in = 64'h0101010101010101; #2;
    chk("teta_ack_pulse", 64'(teta_ack), 64'd1);
    chk("teta_gnt_blocked", 64'(gnt), 64'd0);
    tick(); teta_wr = 1'b0; req = 4'b0001; #2;
    chk("teta_ack_low", 64'(teta_ack), 64'd0);
    chk("teta_loaded", ph_teta, 64'h0101010101010101);
    chk("first_gnt", 64'(gnt), 64'b0001);
    tick(); req = 4'b0000; #2;
    chk("t1_ph_x", ph_x, 64'h0202020202020202);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    tick(); #2;
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2_rsp_id", 64'(rsp_id), 64'd0);
    chk("t2_rsp_h", 64'(rsp_h), 64'h10);
    tick(); #2;
    chk("t3_idle", 64'(busy), 64'd0);

    // all requesting, full throughput; ptr is 0 so requester 1 is next
    tick(); req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #2;
      e_gnt = 4'b0001 << ((i + 1) % 4);
      chk("rr_gnt", 64'(gnt), 64'(e_gnt));
      tick();
    end
    req = 4'b0000;
    tick(); tick(); tick(); #2;
    chk("rr_drained", 64'(busy), 64'd0);

    // requesters 1 and 3 only, ptr is 1
    tick(); req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #2;
      e_gnt = (i % 2 == 0) ? 4'b1000 : 4'b0010;
      chk("pair_gnt", 64'(gnt), 64'(e_gnt));
      tick();
    end
    req = 4'b0000;
    tick(); tick(); tick();

    // backpressure: rsp_ready low for 5 cycles
    tick(); rsp_ready = 1'b0; req = 4'b1111; n_gnt = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      if (gnt != 4'b0) n_gnt++;
      if (i == 2) held_h = rsp_h;
      if (i >= 2) begin
        chk("stall_gnt", 64'(gnt), 64'd0);
        chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("stall_rsp_id", 64'(rsp_id), 64'd2);
        chk("stall_rsp_h", 64'(rsp_h), 64'h20);
        chk("stall_rsp_h_stable", 64'(rsp_h), 64'(held_h));
      end
      tick();
    end
    chk("stall_grant_count", 64'(n_gnt), 64'd2);
    rsp_ready = 1'b1; #2;
    chk("release_gnt", 64'(gnt), 64'b0001);
    tick(); req = 4'b0000;
    tick(); tick(); tick(); #2;
    chk("stall_drained", 64'(busy), 64'd0);

    // teta change while a sample is in flight
    tick(); req = 4'b0010; #2;
    chk("tw_gnt_T", 64'(gnt), 64'b0010);
    tick(); teta_wr = 1'b1; teta_in = 64'h0303030303030303; #2;
    chk("tw_ack_wait", 64'(teta_ack), 64'd0);
    chk("tw_gnt_wait", 64'(gnt), 64'd0);
    tick(); #2;
    chk("tw_ack", 64'(teta_ack), 64'd1);
    chk("tw_gnt_ack", 64'(gnt), 64'd0);
    chk("tw_old_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("tw_old_rsp_h", 64'(rsp_h), 64'h18);
    tick(); teta_wr = 1'b0; #2;
    chk("tw_gnt_after", 64'(gnt), 64'b0010);
    chk("tw_new_teta", ph_teta, 64'h0303030303030303);
    tick(); req = 4'b0000;
    tick(); tick(); #2;
    chk("tw_new_rsp_h", 64'(rsp_h), 64'h48);
    tick();

    // asynchronous reset with both stages full
    tick(); rsp_ready = 1'b0; req = 4'b1111;
    tick(); tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    rst = 1'b1; #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_gnt", 64'(gnt), 64'd0);
    chk("arst_ph_x", ph_x, 64'd0);
    chk("arst_ph_teta", ph_teta, 64'd0);
    chk("arst_rsp_h", 64'(rsp_h), 64'd0);
    chk("arst_rsp_id", 64'(rsp_id), 64'd0);
    tick(); tick();
    rst = 1'b0; req = 4'b0000; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    req = 4'b1111; #2;
    chk("post_rst_first_gnt", 64'(gnt), 64'b0001);
    tick(); req = 4'b0000;
    tick(); tick(); tick(); #2;
    chk("final_idle", 64'(busy), 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
